// File: rtl/det_scan_arbiter_if.sv
// Requester-side bundle of det_scan_arbiter: level requests and words in, grant/status/result out.
interface det_scan_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int CW    = 5
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] word_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [CW-1:0]         match_cnt;

    modport master (
        output req,
        output word_in,
        input  gnt,
        input  busy,
        input  done,
        input  match_cnt
    );

    modport slave (
        input  req,
        input  word_in,
        output gnt,
        output busy,
        output done,
        output match_cnt
    );
endinterface

// File: rtl/det_scan_arbiter.sv
// Round-robin sharing of one serial sequence detector: winner's word is shifted in MSB-first, matches counted.
// done pulses WIDTH+4 cycles after req is sampled; requests wait in IDLE, one job per WIDTH+5 cycles.
module det_scan_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    det_scan_arbiter_if.slave bus,
    output logic              det_rst,
    output logic              det_din,
    input  logic              det_dout
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARM,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    pick;
    logic             pick_vld;
    logic [NREQ-1:0]  pick_oh;
    logic [WIDTH-1:0] sh;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [NREQ-1:0]  gnt;
    logic             busy;
    logic             done;
    logic             sample;

    assign bus.gnt       = gnt;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.match_cnt = cnt;

    // First set request at or after rr_ptr; scanning downward leaves the nearest one last.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[(int'(rr_ptr) + i) % NREQ]) begin
                pick_vld = 1'b1;
                pick     = PW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    // SHIFT cycle 0 still shows the detector's s0 output, so it is skipped; DRAIN covers the last bit.
    assign sample = det_dout && (((state == SHIFT) && (idx != '0)) || (state == DRAIN));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            win     <= '0;
            sh      <= '0;
            idx     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            det_rst <= 1'b1;
            det_din <= 1'b0;
        end else begin
            if (sample && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    det_rst <= 1'b0;
                    det_din <= 1'b0;
                    done    <= 1'b0;
                    if (pick_vld) begin
                        sh      <= bus.word_in[int'(pick)*WIDTH +: WIDTH];
                        gnt     <= pick_oh;
                        win     <= pick;
                        cnt     <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        det_rst <= 1'b1;
                        state   <= LOAD;
                    end
                end

                LOAD: begin
                    det_rst <= 1'b0;
                    det_din <= 1'b0;
                    state   <= WARM;
                end

                // det_din is registered, so the first bit is launched on the edge into SHIFT.
                WARM: begin
                    det_din <= sh[WIDTH-1];
                    sh      <= sh << 1;
                    state   <= SHIFT;
                end

                SHIFT: begin
                    if (idx == IW'(WIDTH - 1)) begin
                        det_din <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        det_din <= sh[WIDTH-1];
                        sh      <= sh << 1;
                        idx     <= idx + 1'b1;
                    end
                end

                DRAIN: begin
                    det_din <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end

                DONE: begin
                    done   <= 1'b0;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_det_scan_arbiter.sv
// Directed bench for det_scan_arbiter with a behavioural overlapping "1001" Moore detector attached.
module tb_det_scan_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic rst;
    logic det_rst;
    logic det_din;
    logic det_dout;
    int   total = 0;
    int   bad   = 0;

    det_scan_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CW(CW)) bus ();

    det_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .det_rst  (det_rst),
        .det_din  (det_din),
        .det_dout (det_dout)
    );

    always #5 clk = ~clk;

    // Reference detector: idle -> s0 unconditionally, then tracks the suffix of "1001".
    typedef enum logic [2:0] {D_IDLE, D_S0, D_S1, D_S2, D_S3, D_S4} dst_t;
    dst_t ds;

    always @(posedge clk) begin
        if (det_rst) begin
            ds <= D_IDLE;
        end else begin
            case (ds)
                D_IDLE:  ds <= D_S0;
                D_S0:    ds <= det_din ? D_S1 : D_S0;
                D_S1:    ds <= det_din ? D_S1 : D_S2;
                D_S2:    ds <= det_din ? D_S1 : D_S3;
                D_S3:    ds <= det_din ? D_S4 : D_S0;
                D_S4:    ds <= det_din ? D_S1 : D_S2;
                default: ds <= D_IDLE;
            endcase
        end
    end

    assign det_dout = (ds == D_S4);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in an IDLE cycle (cycle 0); leaves in the IDLE cycle after DONE.
    task automatic run_job(input logic [NREQ-1:0] reqv, input logic [WIDTH-1:0] w, input int slot,
                           input logic [NREQ-1:0] eg, input logic [CW-1:0] ec, input bit drop);
        logic [WIDTH-1:0] seq;
        seq = '0;
        bus.req = reqv;
        bus.word_in[slot*WIDTH +: WIDTH] = w;
        for (int c = 1; c <= WIDTH + 4; c++) begin
            step();
            if (c == 1 && drop) begin
                bus.req = '0;
                bus.word_in[slot*WIDTH +: WIDTH] = ~w;
            end
            chk("gnt", bus.gnt, eg);
            chk("busy", bus.busy, 1);
            chk("done", bus.done, (c == WIDTH + 4) ? 1 : 0);
            if (c == 1) chk("det_rst_load", det_rst, 1);
            if (c == 2) chk("det_rst_warm", det_rst, 0);
            if (c >= 3 && c <= WIDTH + 2) seq[WIDTH + 2 - c] = det_din;
        end
        chk("match_cnt", bus.match_cnt, ec);
        chk("din_seq", seq, w);
        step();
        chk("idle_gnt", bus.gnt, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("cnt_hold", bus.match_cnt, ec);
    endtask

    initial begin
        rst         = 1'b0;
        bus.req     = '0;
        bus.word_in = '0;

        step();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cnt", bus.match_cnt, 0);
        chk("rst_det_rst", det_rst, 1);
        step();
        step();
        rst = 1'b1;
        step();
        step();
        chk("idle_det_rst", det_rst, 0);
        chk("idle_gnt0", bus.gnt, 0);
        chk("idle_busy0", bus.busy, 0);

        // Round robin with all requests held.
        run_job(4'b1111, 16'h9000, 0, 4'b0001, 5'd1, 1'b0);
        run_job(4'b1111, 16'h9200, 1, 4'b0010, 5'd2, 1'b0);
        run_job(4'b1111, 16'h0009, 2, 4'b0100, 5'd1, 1'b0);
        run_job(4'b1111, 16'hFFFF, 3, 4'b1000, 5'd0, 1'b0);
        run_job(4'b1111, 16'h9090, 0, 4'b0001, 5'd2, 1'b0);

        // Single requester, req dropped and word changed right after the grant.
        run_job(4'b0001, 16'h9000, 0, 4'b0001, 5'd1, 1'b1);
        run_job(4'b0001, 16'h9090, 0, 4'b0001, 5'd2, 1'b1);
        run_job(4'b0001, 16'h0000, 0, 4'b0001, 5'd0, 1'b1);
        run_job(4'b0001, 16'hFFFF, 0, 4'b0001, 5'd0, 1'b1);
        run_job(4'b0001, 16'h0009, 0, 4'b0001, 5'd1, 1'b1);

        // Abort a job mid-SHIFT; rr_ptr is 1 here, so 0101 would go to requester 2 without reset.
        bus.req = 4'b0100;
        bus.word_in[2*WIDTH +: WIDTH] = 16'h9090;
        for (int c = 1; c <= 8; c++) step();
        chk("abort_gnt_before", bus.gnt, 4'b0100);
        rst     = 1'b0;
        bus.req = 4'b0101;
        step();
        chk("abort_gnt", bus.gnt, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_cnt", bus.match_cnt, 0);
        chk("abort_det_rst", det_rst, 1);
        step();
        rst = 1'b1;
        run_job(4'b0101, 16'h9000, 0, 4'b0001, 5'd1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
